i2s_rx: RTL and testbench
=========================

# i2s_rx

Audio-codec capture path: I2S master receiver that generates BCLK and RECLRC from `in_clk` (73.728 MHz) and deserialises left-justified 24-bit stereo samples from the codec's RECDAT pin. It is the capture-side counterpart of the playback transmitter. It sits between the codec pins and the DSP/FIFO, and delivers one left/right pair per 48 kHz frame through a valid/ready handshake.

## Interface
- `BPS`, 24: data bits per channel, MSB first; legal range 1..`SLOT`.
- `SLOT`, 32: BCLK periods per channel slot; a frame is 2·`SLOT` BCLK periods.
- `BCLK_HALF`, 12: `in_clk` cycles per BCLK half-period; 12 gives 3.072 MHz.

Ports:
- `in_clk` in 1: system clock, 73.728 MHz.
- `in_rst` in 1: reset, **asynchronous, active-high**.
- `in_en` in 1: run enable. Low forces IDLE.
- `in_RECDAT` in 1: serial data from the codec, changes after BCLK falling edges.
- `out_BCLK` out 1: bit clock.
- `out_RECLRC` out 1: frame clock; 1 = left slot, 0 = right slot.
- `out_left` out `BPS`: captured left sample.
- `out_right` out `BPS`: captured right sample.
- `out_valid` out 1: sample pair available.
- `in_ready` in 1: consumer accepts the pair.
- `out_overrun` out 1: sticky flag, set when a pair was dropped.
- `out_busy` out 1: state == RUN.

## Operation
- States are IDLE and RUN.
- **IDLE → RUN**
  - Taken when `in_en` = 1.
  - On entry: div counter = 0, bit counter = 0, `out_BCLK` = 0 (first falling edge), `out_RECLRC` = 1.
- **RUN → IDLE**
  - Taken on any cycle with `in_en` = 0.
  - The partial frame is discarded.
  - A pending valid pair is kept until accepted.
- **BCLK generation in RUN**
  - The div counter runs 0..`BCLK_HALF`-1. At the wrap, `out_BCLK` toggles.
  - Rising tick: wrap cycle with BCLK = 0.
  - Falling tick: wrap cycle with BCLK = 1. The bit counter advances mod 2·`SLOT`, and `out_RECLRC` ← (bit counter next < `SLOT`).
- **Capture**
  - On a rising tick with slot bit index i = bit counter mod `SLOT`, and i < `BPS`: shift the data bit into that channel's shift register (MSB first).
  - Slot bits `BPS`..`SLOT`-1 are ignored.
- **Pair completion** (rising tick with bit counter = `SLOT` + `BPS`-1)
  - The completed left register and the right register, including the bit being captured, form the pair.
  - If `out_valid` = 0, or `in_ready` = 1 on that cycle: load `out_left`/`out_right` and set `out_valid` = 1.
  - Otherwise: drop the new pair, keep the old outputs, set `out_overrun` = 1.
- **Handshake**
  - Transfer happens when `out_valid` & `in_ready`. `out_valid` clears next cycle unless a new pair loads on the same cycle.
  - `out_left`/`out_right` are stable while `out_valid` = 1.
- `out_overrun` clears only on `in_rst` or in IDLE.

## Timing
- **Reset values:** `out_BCLK` = 1, `out_RECLRC` = 1, `out_left` = 0, `out_right` = 0, `out_valid` = 0, `out_overrun` = 0, `out_busy` = 0. All counters and shift registers = 0. IDLE also drives BCLK = 1 and RECLRC = 1.
- **Periods:** BCLK = 2·`BCLK_HALF` = 24 cycles. RECLRC = 2·`SLOT`·24 = 1536 cycles (48 kHz). RECLRC edges coincide with BCLK falling edges.
- **Sample point:** rising tick, 12 cycles after the falling edge on which the codec launched the bit.
- **Latency:** `out_valid` rises the cycle after the right-channel bit `BPS`-1 rising tick. That is 55·24 + 13 = 1333 cycles after the RUN entry cycle for the first frame, then every 1536 cycles.
- **Reset mid-operation:** all outputs return to reset values asynchronously. After release, the block waits in IDLE for `in_en`.
- **Simultaneous pair completion and accept:** the new pair loads, `out_valid` stays 1, no overrun.

## Configuration
- Macro: `I2S_RX_SYNC_EN`.
- **Defined:**
  - `in_RECDAT` passes through a two-flop synchroniser before capture.
  - The captured bit equals `in_RECDAT` as registered 2 cycles before the rising tick.
  - Pair latency is unchanged, because the same tick is used.
- **Undefined:**
  - `in_RECDAT` is sampled directly on the rising-tick cycle.
  - For board use with an unsynchronised pad, the macro is defined.

## Test plan
- **Reset:** assert `in_rst` mid-RUN → all outputs at reset values immediately; `out_busy` = 0 until `in_en`.
- **Basic capture:** codec model drives left 0xABCDEF, right 0x123456 on BCLK falls → `out_left` = 0xABCDEF, `out_right` = 0x123456, `out_valid` rises 1333 cycles after RUN entry.
- **Clock timing:** measure BCLK period = 24 cycles, RECLRC period = 1536 cycles, RECLRC toggles only with BCLK falling, RECLRC = 1 during the first 32 BCLKs.
- **Backpressure:** hold `in_ready` = 0 over two frames (0x000001/0x000002, then 0x000003/0x000004) → outputs stay 0x000001/0x000002 and `out_overrun` = 1. Pulse `in_ready` → `out_valid` drops next cycle.
- **Enable drop:** deassert `in_en` at left bit 10 → next cycle BCLK = 1, RECLRC = 1, `out_busy` = 0, no new `out_valid`. Re-enable → the next pair is correct.
- **Synchroniser:** `in_RECDAT` = 1 only on the cycle 2 before each rising tick → captures all-ones with `I2S_RX_SYNC_EN` defined, all-zeros without it.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S master receiver: generates BCLK/RECLRC and deserialises left-justified stereo samples.
// Define I2S_RX_SYNC_EN to pass in_RECDAT through a two-flop synchroniser before capture.
module i2s_rx #(
  parameter int unsigned BPS       = 24,
  parameter int unsigned SLOT      = 32,
  parameter int unsigned BCLK_HALF = 12
) (
  input  logic           in_clk,
  input  logic           in_rst,
  input  logic           in_en,
  input  logic           in_RECDAT,
  output logic           out_BCLK,
  output logic           out_RECLRC,
  output logic [BPS-1:0] out_left,
  output logic [BPS-1:0] out_right,
  output logic           out_valid,
  input  logic           in_ready,
  output logic           out_overrun,
  output logic           out_busy
);

  localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned BitW = $clog2(2 * SLOT);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic            bclk_q, bclk_d;
  logic            lrc_q, lrc_d;
  logic [BPS-1:0]  lsr_q, lsr_d;
  logic [BPS-1:0]  rsr_q, rsr_d;
  logic [BPS-1:0]  left_q, left_d;
  logic [BPS-1:0]  right_q, right_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  logic            data_bit;
  logic            div_wrap;
  logic            in_left;
  logic [BitW-1:0] slot_idx;
  logic [BitW-1:0] bit_inc;
  logic            pair_done;
  logic [BPS-1:0]  left_shift;
  logic [BPS-1:0]  right_shift;

`ifdef I2S_RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in_RECDAT;
      sync2_q <= sync1_q;
    end
  end

  assign data_bit = sync2_q;
`else
  assign data_bit = in_RECDAT;
`endif

  assign div_wrap    = (div_q == DivW'(BCLK_HALF - 1));
  assign in_left     = (bit_q < BitW'(SLOT));
  assign slot_idx    = in_left ? bit_q : (bit_q - BitW'(SLOT));
  assign bit_inc     = (bit_q == BitW'(2 * SLOT - 1)) ? '0 : (bit_q + 1'b1);
  assign pair_done   = (bit_q == BitW'(SLOT + BPS - 1));
  assign left_shift  = (lsr_q << 1) | BPS'(data_bit);
  assign right_shift = (rsr_q << 1) | BPS'(data_bit);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    bclk_d    = bclk_q;
    lrc_d     = lrc_q;
    lsr_d     = lsr_q;
    rsr_d     = rsr_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // Handshake runs in both states so a pending pair survives a drop of in_en.
    if (valid_q && in_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        div_d     = '0;
        bit_d     = '0;
        bclk_d    = 1'b1;
        lrc_d     = 1'b1;
        lsr_d     = '0;
        rsr_d     = '0;
        overrun_d = 1'b0;
        if (in_en) begin
          state_d = StRun;
          bclk_d  = 1'b0;
        end
      end
      StRun: begin
        if (!in_en) begin
          state_d = StIdle;
          div_d   = '0;
          bit_d   = '0;
          bclk_d  = 1'b1;
          lrc_d   = 1'b1;
          lsr_d   = '0;
          rsr_d   = '0;
        end else if (div_wrap) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          if (!bclk_q) begin
            if (slot_idx < BitW'(BPS)) begin
              if (in_left) begin
                lsr_d = left_shift;
              end else begin
                rsr_d = right_shift;
              end
            end
            // The right word is completed by the bit captured on this very tick.
            if (pair_done) begin
              if (!valid_q || in_ready) begin
                left_d  = lsr_q;
                right_d = right_shift;
                valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end else begin
            bit_d = bit_inc;
            lrc_d = (bit_inc < BitW'(SLOT));
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      bclk_q    <= 1'b1;
      lrc_q     <= 1'b1;
      lsr_q     <= '0;
      rsr_q     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      bclk_q    <= bclk_d;
      lrc_q     <= lrc_d;
      lsr_q     <= lsr_d;
      rsr_q     <= rsr_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_BCLK    = bclk_q;
  assign out_RECLRC  = lrc_q;
  assign out_left    = left_q;
  assign out_right   = right_q;
  assign out_valid   = valid_q;
  assign out_overrun = overrun_q;
  assign out_busy    = (state_q == StRun);

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: codec model feeds pairs, expected pairs go through a scoreboard queue.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int BPS         = 24;
  localparam int SLOT        = 32;
  localparam int BCLK_HALF   = 12;
  localparam int BCLK_PER    = 2 * BCLK_HALF;
  localparam int FRAME       = 2 * SLOT * BCLK_PER;
  localparam int FIRST_VALID = (SLOT + BPS - 1) * BCLK_PER + BCLK_HALF + 1;

  logic           in_clk = 1'b0;
  logic           in_rst = 1'b1;
  logic           in_en = 1'b0;
  logic           in_RECDAT = 1'b0;
  logic           in_ready = 1'b0;
  logic           out_BCLK;
  logic           out_RECLRC;
  logic [BPS-1:0] out_left;
  logic [BPS-1:0] out_right;
  logic           out_valid;
  logic           out_overrun;
  logic           out_busy;

  logic [2*BPS-1:0] stim_q[$];
  logic [2*BPS-1:0] exp_q[$];
  logic             codec_on = 1'b1;
  logic             sync_bit = 1'b0;
  int               vectors = 0;
  int               miscompares = 0;

  i2s_rx #(
    .BPS      (BPS),
    .SLOT     (SLOT),
    .BCLK_HALF(BCLK_HALF)
  ) dut (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_en      (in_en),
    .in_RECDAT  (in_RECDAT),
    .out_BCLK   (out_BCLK),
    .out_RECLRC (out_RECLRC),
    .out_left   (out_left),
    .out_right  (out_right),
    .out_valid  (out_valid),
    .in_ready   (in_ready),
    .out_overrun(out_overrun),
    .out_busy   (out_busy)
  );

  initial forever #5 in_clk = ~in_clk;

  // Codec: launches the next bit after each BCLK fall, slot restarts on a RECLRC change.
  initial begin : codec
    int               idx;
    logic             pb;
    logic             pl;
    logic [BPS-1:0]   cl;
    logic [BPS-1:0]   cr;
    logic [2*BPS-1:0] pr;
    idx = -1; pb = 1'b1; pl = 1'b1; cl = '0; cr = '0;
    forever begin
      @(posedge in_clk);
      #2;
      if (!codec_on || !out_busy) begin
        idx = -1; pb = 1'b1; pl = 1'b1;
      end else begin
        if (pb && !out_BCLK) begin
          if (idx < 0 || out_RECLRC != pl) idx = 0;
          else idx++;
          pl = out_RECLRC;
          if (idx == 0 && pl) begin
            if (stim_q.size() > 0) pr = stim_q.pop_front();
            else pr = '0;
            cl = pr[2*BPS-1:BPS];
            cr = pr[BPS-1:0];
          end
        end
        pb = out_BCLK;
      end
      if (codec_on) in_RECDAT = (idx >= 0 && idx < BPS) ? (pl ? cl[BPS-1-idx] : cr[BPS-1-idx]) : 1'b0;
      else in_RECDAT = sync_bit;
    end
  end

  // Scoreboard: every accepted pair must match the head of exp_q.
  initial begin : monitor
    logic [2*BPS-1:0] want;
    forever begin
      @(negedge in_clk);
      if (out_valid && in_ready && !in_rst) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pair: got %h_%h, none expected", out_left, out_right);
        end else begin
          want = exp_q.pop_front();
          if ({out_left, out_right} !== want) begin
            miscompares++;
            $display("FAIL pair: got %h_%h want %h_%h", out_left, out_right,
                     want[2*BPS-1:BPS], want[BPS-1:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst = 1'b1; in_en = 1'b0; in_ready = 1'b0; sync_bit = 1'b0; codec_on = 1'b1;
    stim_q.delete();
    exp_q.delete();
    tick(); tick();
    in_rst = 1'b0;
    tick();
  endtask

  // Enables the block and returns the number of edges (entry edge included) until out_valid.
  task automatic run_to_valid(output int n);
    in_en = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 3000);
    if (!out_valid) begin
      miscompares++;
      $display("FAIL valid_timeout: out_valid still 0 after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    int n;
    vectors++;
    if ({out_BCLK, out_RECLRC, out_valid, out_overrun, out_busy} !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 11000",
               {out_BCLK, out_RECLRC, out_valid, out_overrun, out_busy});
    end
    vectors++;
    if ({out_left, out_right} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %h_%h want 0_0", out_left, out_right);
    end
    stim_q.push_back({24'hC0FFEE, 24'h0BEEF1});
    run_to_valid(n);
    repeat (50) tick();
    vectors++;
    if ({out_valid, out_busy, out_left} !== {2'b11, 24'hC0FFEE}) begin
      miscompares++;
      $display("FAIL pre_reset: got v%b b%b %h want v1 b1 c0ffee", out_valid, out_busy, out_left);
    end
    #2 in_rst = 1'b1;
    #1;
    vectors++;
    if ({out_BCLK, out_RECLRC, out_valid, out_overrun, out_busy, out_left, out_right}
        !== {5'b11000, 48'h0}) begin
      miscompares++;
      $display("FAIL async_reset: got %b %h_%h want 11000 0_0",
               {out_BCLK, out_RECLRC, out_valid, out_overrun, out_busy}, out_left, out_right);
    end
    in_en = 1'b0;
    tick(); tick();
    in_rst = 1'b0;
    repeat (5) tick();
    vectors++;
    if (out_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy got %b want 0", out_busy);
    end
    in_en = 1'b1;
    tick();
    vectors++;
    if (out_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL run_after_en: busy got %b want 1", out_busy);
    end
    in_en = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    stim_q.push_back({24'hABCDEF, 24'h123456});
    exp_q.push_back({24'hABCDEF, 24'h123456});
    run_to_valid(n);
    vectors++;
    if (n != FIRST_VALID) begin
      miscompares++;
      $display("FAIL first_latency: got %0d want %0d", n, FIRST_VALID);
    end
    repeat (10) tick();
    vectors++;
    if ({out_valid, out_left, out_right} !== {1'b1, 24'hABCDEF, 24'h123456}) begin
      miscompares++;
      $display("FAIL hold_pair: got v%b %h_%h want v1 abcdef_123456", out_valid, out_left, out_right);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_clear: got %b want 0", out_valid);
    end
    in_en = 1'b0;
    tick();
  endtask

  task automatic test_clock_timing();
    logic pb, pl, b, l;
    int   last_brise, last_lrise, lrc_per, bad_bclk, bad_lrc, rises, rises_left, lfall_seen;
    do_reset();
    pb = out_BCLK; pl = out_RECLRC;
    last_brise = -1; last_lrise = -1; lrc_per = 0; bad_bclk = 0; bad_lrc = 0;
    rises = 0; rises_left = 0; lfall_seen = 0;
    in_en = 1'b1;
    for (int c = 0; c < 3600; c++) begin
      tick();
      b = out_BCLK; l = out_RECLRC;
      if (!pb && b) begin
        if (last_brise >= 0 && c - last_brise != BCLK_PER) bad_bclk++;
        last_brise = c;
        rises++;
        if (!lfall_seen && l) rises_left++;
      end
      if (l != pl && !(pb && !b)) bad_lrc++;
      if (pl && !l) lfall_seen = 1;
      if (!pl && l) begin
        if (last_lrise >= 0) lrc_per = c - last_lrise;
        last_lrise = c;
      end
      pb = b; pl = l;
    end
    vectors++;
    if (bad_bclk != 0 || rises < 100) begin
      miscompares++;
      $display("FAIL bclk_period: %0d bad periods of %0d rises, want 0 bad", bad_bclk, rises);
    end
    vectors++;
    if (lrc_per != FRAME) begin
      miscompares++;
      $display("FAIL lrc_period: got %0d want %0d", lrc_per, FRAME);
    end
    vectors++;
    if (bad_lrc != 0) begin
      miscompares++;
      $display("FAIL lrc_edge: %0d RECLRC changes off a BCLK fall, want 0", bad_lrc);
    end
    vectors++;
    if (rises_left != SLOT) begin
      miscompares++;
      $display("FAIL lrc_first_slot: got %0d BCLKs with RECLRC=1 want %0d", rises_left, SLOT);
    end
    in_en = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    stim_q.push_back({24'h000001, 24'h000002});
    stim_q.push_back({24'h000003, 24'h000004});
    exp_q.push_back({24'h000001, 24'h000002});
    run_to_valid(n);
    repeat (1600) tick();
    vectors++;
    if ({out_valid, out_overrun, out_left, out_right} !== {2'b11, 24'h000001, 24'h000002}) begin
      miscompares++;
      $display("FAIL overrun_hold: got v%b o%b %h_%h want v1 o1 000001_000002",
               out_valid, out_overrun, out_left, out_right);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_valid_clear: got %b want 0", out_valid);
    end
    in_en = 1'b0;
    tick(); tick();
    vectors++;
    if (out_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_idle_clear: got %b want 0", out_overrun);
    end
  endtask

  task automatic test_enable_drop();
    int n, seen;
    do_reset();
    stim_q.push_back({24'h5A5A5A, 24'hA5A5A5});
    in_en = 1'b1;
    repeat (253) tick();
    in_en = 1'b0;
    tick();
    vectors++;
    if ({out_BCLK, out_RECLRC, out_busy} !== 3'b110) begin
      miscompares++;
      $display("FAIL drop_idle: got %b want 110", {out_BCLK, out_RECLRC, out_busy});
    end
    seen = 0;
    repeat (2000) begin
      tick();
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL drop_no_valid: valid high %0d cycles want 0", seen);
    end
    stim_q.push_back({24'h13579B, 24'h2468AC});
    exp_q.push_back({24'h13579B, 24'h2468AC});
    run_to_valid(n);
    vectors++;
    if (n != FIRST_VALID) begin
      miscompares++;
      $display("FAIL reenable_latency: got %0d want %0d", n, FIRST_VALID);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    in_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    stim_q.push_back({24'h111111, 24'h222222});
    stim_q.push_back({24'h333333, 24'h444444});
    exp_q.push_back({24'h111111, 24'h222222});
    exp_q.push_back({24'h333333, 24'h444444});
    run_to_valid(n);
    while (n < FIRST_VALID + FRAME - 1) begin
      tick();
      n++;
    end
    vectors++;
    if ({out_valid, out_left} !== {1'b1, 24'h111111}) begin
      miscompares++;
      $display("FAIL b2b_first: got v%b %h want v1 111111", out_valid, out_left);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    vectors++;
    if ({out_valid, out_overrun, out_left, out_right} !== {2'b10, 24'h333333, 24'h444444}) begin
      miscompares++;
      $display("FAIL b2b_reload: got v%b o%b %h_%h want v1 o0 333333_444444",
               out_valid, out_overrun, out_left, out_right);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    in_en = 1'b0;
    tick();
  endtask

  task automatic test_sync();
    int p;
    logic [2*BPS-1:0] want;
    do_reset();
    codec_on = 1'b0;
`ifdef I2S_RX_SYNC_EN
    want = {2*BPS{1'b1}};
`else
    want = '0;
`endif
    exp_q.push_back(want);
    in_en = 1'b1;
    p = -1;
    // Pulse only during the cycle that ends two edges before each rising tick.
    do begin
      tick();
      p++;
      sync_bit = (p >= 9 && (p - 9) % BCLK_PER == 0);
    end while (!out_valid && p < 3000);
    sync_bit = 1'b0;
    vectors++;
    if ({out_valid, out_left, out_right} !== {1'b1, want}) begin
      miscompares++;
      $display("FAIL sync_capture: got v%b %h_%h want v1 %h", out_valid, out_left, out_right, want);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    in_en = 1'b0;
    codec_on = 1'b1;
    tick();
  endtask

  initial begin
    tick(); tick();
    in_rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_clock_timing();
    test_backpressure();
    test_enable_drop();
    test_back_to_back();
    test_sync();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_pairs: %0d expected pairs never delivered", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
